// File: rtl/fifo_status_pkg.sv
// Shared types and helpers for the multi-channel FIFO status/LED controller.
//   blink_state_t : states of the error blink-code sequencer
//   lowest_set()  : index of the lowest set bit of a (zero-extended) flag vector
package fifo_status_pkg;

  localparam int MAX_CH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    GAP  = 2'd3
  } blink_state_t;

  // Walks from the top down so the last hit is the lowest index; returns 0
  // for an all-zero vector (callers only use it when some bit is set).
  function automatic logic [3:0] lowest_set(input logic [MAX_CH-1:0] vec);
    logic [3:0] idx;
    idx = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (vec[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_multi_ch_status_led_sync_bit.sv
// status_sync_bit: SYNC_STAGE-deep flop chain bringing one asynchronous level
// into the led_clk domain.
//   led_clk : destination clock
//   sys_rst : asynchronous, active-high reset (chain clears to 0)
//   d       : asynchronous input level
//   q       : synchronised level, SYNC_STAGE cycles behind d
module status_sync_bit #(
  parameter int SYNC_STAGE = 2
) (
  input  logic led_clk,
  input  logic sys_rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGE-1:0] chain;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) chain <= '0;
    else         chain <= {chain[SYNC_STAGE-2:0], d};
  end

  assign q = chain[SYNC_STAGE-1];

endmodule

// File: rtl/fifo_multi_ch_status_led.sv
// fifo_multi_ch_status_led: status/LED controller for NUM_CH FIFO self-test
// channels living in unrelated clock domains.
//   led_clk, sys_rst : block clock, asynchronous active-high reset
//   ch_error_i       : per-channel compare-error level (async)
//   ch_full_i        : per-channel FIFO full level (async)
//   ch_empty_i       : per-channel FIFO empty level (async)
//   err_clear_i      : synchronous clear of flags, counters and blink sequencer
//   led_blink_o      : heartbeat, toggles on every prescaler tick
//   led_error_o      : blink code, k+1 pulses for lowest failing channel k
//   led_full_o       : OR of synchronised full levels (registered)
//   led_empty_o      : AND of synchronised empty levels (registered)
//   err_flag_o       : per-channel error flag (sticky or live, see MODE)
//   err_cnt_o        : saturating error-event counters, channel 0 in LSBs
module fifo_multi_ch_status_led
  import fifo_status_pkg::*;
#(
  parameter int    NUM_CH     = 4,
  parameter int    SYNC_STAGE = 2,
  parameter int    DIV_W      = 20,
  parameter int    ERR_CNT_W  = 8,
  parameter int    GAP_TICKS  = 4,
  parameter string MODE       = "STICKY"
) (
  input  logic                        led_clk,
  input  logic                        sys_rst,
  input  logic [NUM_CH-1:0]           ch_error_i,
  input  logic [NUM_CH-1:0]           ch_full_i,
  input  logic [NUM_CH-1:0]           ch_empty_i,
  input  logic                        err_clear_i,
  output logic                        led_blink_o,
  output logic                        led_error_o,
  output logic                        led_full_o,
  output logic                        led_empty_o,
  output logic [NUM_CH-1:0]           err_flag_o,
  output logic [NUM_CH*ERR_CNT_W-1:0] err_cnt_o
);

  localparam bit LIVE_MODE = (MODE == "LIVE");
  localparam int CODE_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PULSE_W   = $clog2(NUM_CH + 1);
  localparam int GAP_W     = $clog2(GAP_TICKS + 1);

  // ---------------------------------------------------------------- sync
  logic [NUM_CH-1:0] err_s, full_s, empty_s;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_sync
    status_sync_bit #(.SYNC_STAGE(SYNC_STAGE)) u_err (
      .led_clk (led_clk), .sys_rst (sys_rst), .d (ch_error_i[ch]), .q (err_s[ch])
    );
    status_sync_bit #(.SYNC_STAGE(SYNC_STAGE)) u_full (
      .led_clk (led_clk), .sys_rst (sys_rst), .d (ch_full_i[ch]), .q (full_s[ch])
    );
    status_sync_bit #(.SYNC_STAGE(SYNC_STAGE)) u_empty (
      .led_clk (led_clk), .sys_rst (sys_rst), .d (ch_empty_i[ch]), .q (empty_s[ch])
    );
  end

  // ----------------------------------------------------------- prescaler
  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  assign tick = &div_cnt;

  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      div_cnt     <= '0;
      led_blink_o <= 1'b0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
      if (tick) led_blink_o <= ~led_blink_o;
    end
  end

  // ------------------------------------- edge detect, flags and counters
  logic [NUM_CH-1:0]    err_d;
  logic [NUM_CH-1:0]    rise;
  logic [ERR_CNT_W-1:0] err_cnt [NUM_CH];

  assign rise = err_s & ~err_d;

  // err_d keeps tracking during a clear, so an edge coinciding with the
  // clear is consumed and never counted afterwards.
  // NOTE: the counter array is a handful of flops, not a RAM, so it takes
  // the async reset like every other register in the block.
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      err_d      <= '0;
      err_flag_o <= '0;
      for (int ch = 0; ch < NUM_CH; ch++) err_cnt[ch] <= '0;
    end else begin
      err_d <= err_s;
      if (err_clear_i) begin
        err_flag_o <= '0;
        for (int ch = 0; ch < NUM_CH; ch++) err_cnt[ch] <= '0;
      end else begin
        if (LIVE_MODE) err_flag_o <= err_s;
        else           err_flag_o <= err_flag_o | rise;
        for (int ch = 0; ch < NUM_CH; ch++) begin
          if (rise[ch] && !(&err_cnt[ch])) err_cnt[ch] <= err_cnt[ch] + ERR_CNT_W'(1);
        end
      end
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_cnt_pack
    assign err_cnt_o[ch*ERR_CNT_W +: ERR_CNT_W] = err_cnt[ch];
  end

  // ------------------------------------------------- full/empty aggregates
  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      led_full_o  <= 1'b0;
      led_empty_o <= 1'b0;
    end else begin
      led_full_o  <= |full_s;
      led_empty_o <= &empty_s;
    end
  end

  // ------------------------------------------------- blink-code sequencer
  blink_state_t       state, state_nxt;
  logic [CODE_W-1:0]  code, code_nxt;
  logic [PULSE_W-1:0] pulse_cnt, pulse_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;

  always_ff @(posedge led_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state     <= IDLE;
      code      <= '0;
      pulse_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      code      <= code_nxt;
      pulse_cnt <= pulse_nxt;
      gap_cnt   <= gap_nxt;
    end
  end

  // NOTE: every variable gets its hold value before the case so no path
  // leaves one unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    code_nxt  = code;
    pulse_nxt = pulse_cnt;
    gap_nxt   = gap_cnt;
    if (err_clear_i) begin
      state_nxt = IDLE;
      code_nxt  = '0;
      pulse_nxt = '0;
      gap_nxt   = '0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          // The code is frozen for the whole sequence; flag changes are
          // only looked at again on the next visit to IDLE.
          if (|err_flag_o) begin
            code_nxt  = CODE_W'(lowest_set(MAX_CH'(err_flag_o)));
            pulse_nxt = '0;
            state_nxt = ON;
          end
        end
        ON:  state_nxt = OFF;
        OFF: begin
          pulse_nxt = pulse_cnt + PULSE_W'(1);
          if (int'(pulse_cnt) + 1 == int'(code) + 1) begin
            gap_nxt   = '0;
            state_nxt = GAP;
          end else begin
            state_nxt = ON;
          end
        end
        GAP: begin
          gap_nxt = gap_cnt + GAP_W'(1);
          if (int'(gap_cnt) + 1 == GAP_TICKS) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign led_error_o = (state == ON);

endmodule
